// File: rtl/bellman_ford_relax.sv
// Bellman-Ford relaxation engine: seeds the vertex matrix, then sweeps every (i,j) edge once per pass.
// Optional macro RELAX_EARLY_EXIT_EN stops after the first pass that changes nothing.
// relax_state is a debug view of the FSM; IDLE encodes as 0.
module bellman_ford_relax #(
  parameter int NODES    = 16,
  parameter int WEIGHT_W = 32,
  parameter int PRED_W   = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       relax_start,
  input  logic [PRED_W-1:0]          source,
  input  logic [WEIGHT_W-1:0]        adjmat_q,
  input  logic [PRED_W+WEIGHT_W-1:0] vertmat_q,
  output logic [PRED_W-1:0]          adjmat_row_addr,
  output logic [PRED_W-1:0]          adjmat_col_addr,
  output logic [PRED_W-1:0]          vertmat_addr,
  output logic [PRED_W+WEIGHT_W-1:0] vertmat_wdata,
  output logic                       vertmat_we,
  output logic                       relax_busy,
  output logic                       relax_done,
  output logic [PRED_W:0]            relax_passes,
  output logic [3:0]                 relax_state
);

  localparam logic [PRED_W-1:0]   LAST      = PRED_W'(NODES - 1);
  localparam logic [PRED_W:0]     LAST_PASS = (PRED_W + 1)'(NODES - 1);
  localparam logic [WEIGHT_W-1:0] INF       = {1'b0, {(WEIGHT_W - 1){1'b1}}};
  localparam logic [WEIGHT_W-1:0] MIN       = {1'b1, {(WEIGHT_W - 1){1'b0}}};
`ifdef RELAX_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_A_SRC, S_A_DST, S_C_DST, S_CMP, S_WR, S_ADV, S_DONE
  } state_t;

  state_t                state;
  logic [PRED_W-1:0]     i, j, n, src;
  logic [WEIGHT_W-1:0]   svw, e, dvw;
  logic                  changed;

  logic signed [WEIGHT_W:0] sum, dvw_x;
  logic [WEIGHT_W-1:0]      clamped;
  logic                     relax;
  logic [PRED_W:0]          passes_inc;
  logic                     unused_pred;

  assign adjmat_row_addr = i;
  assign adjmat_col_addr = j;
  assign relax_state     = state;
  assign unused_pred     = ^vertmat_q[PRED_W+WEIGHT_W-1:WEIGHT_W];

  // One guard bit keeps the sum exact so the compare and clamp see the true value.
  assign sum        = $signed({svw[WEIGHT_W-1], svw}) + $signed({e[WEIGHT_W-1], e});
  assign dvw_x      = $signed({dvw[WEIGHT_W-1], dvw});
  assign relax      = (e != '0) && (svw != INF) && (sum < dvw_x);
  assign passes_inc = relax_passes + 1'b1;

  always_comb begin
    clamped = sum[WEIGHT_W-1:0];
    if (sum > $signed({1'b0, INF}))      clamped = INF;
    else if (sum < $signed({1'b1, MIN})) clamped = MIN;
  end

  function automatic logic [PRED_W+WEIGHT_W-1:0] seed_word(input logic [PRED_W-1:0] v,
                                                           input logic [PRED_W-1:0] s);
    return {v, (v == s) ? {WEIGHT_W{1'b0}} : INF};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      i             <= '0;
      j             <= '0;
      n             <= '0;
      src           <= '0;
      svw           <= '0;
      e             <= '0;
      dvw           <= '0;
      changed       <= 1'b0;
      vertmat_addr  <= '0;
      vertmat_wdata <= '0;
      vertmat_we    <= 1'b0;
      relax_busy    <= 1'b0;
      relax_done    <= 1'b0;
      relax_passes  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (relax_start) begin
            src           <= source;
            n             <= '0;
            relax_passes  <= '0;
            relax_done    <= 1'b0;
            relax_busy    <= 1'b1;
            vertmat_we    <= 1'b1;
            vertmat_addr  <= '0;
            vertmat_wdata <= seed_word('0, source);
            state         <= S_INIT;
          end
        end
        S_INIT: begin
          if (n == LAST) begin
            vertmat_we   <= 1'b0;
            vertmat_addr <= '0;
            i            <= '0;
            j            <= '0;
            changed      <= 1'b0;
            state        <= S_A_SRC;
          end else begin
            n             <= n + 1'b1;
            vertmat_addr  <= n + 1'b1;
            vertmat_wdata <= seed_word(n + 1'b1, src);
          end
        end
        S_A_SRC: begin
          vertmat_addr <= j;
          state        <= S_A_DST;
        end
        S_A_DST: begin
          svw   <= vertmat_q[WEIGHT_W-1:0];
          e     <= adjmat_q;
          state <= S_C_DST;
        end
        S_C_DST: begin
          dvw   <= vertmat_q[WEIGHT_W-1:0];
          state <= S_CMP;
        end
        S_CMP: begin
          if (relax) begin
            vertmat_we    <= 1'b1;
            vertmat_addr  <= j;
            vertmat_wdata <= {i, clamped};
            changed       <= 1'b1;
            state         <= S_WR;
          end else begin
            state <= S_ADV;
          end
        end
        S_WR: begin
          vertmat_we <= 1'b0;
          state      <= S_ADV;
        end
        S_ADV: begin
          if (j == LAST) begin
            j <= '0;
            if (i == LAST) begin
              i            <= '0;
              relax_passes <= passes_inc;
              if (passes_inc == LAST_PASS || (EARLY_EXIT && !changed)) begin
                relax_busy <= 1'b0;
                relax_done <= 1'b1;
                state      <= S_DONE;
              end else begin
                changed      <= 1'b0;
                vertmat_addr <= '0;
                state        <= S_A_SRC;
              end
            end else begin
              i            <= i + 1'b1;
              vertmat_addr <= i + 1'b1;
              state        <= S_A_SRC;
            end
          end else begin
            j            <= j + 1'b1;
            vertmat_addr <= i;
            state        <= S_A_SRC;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
